// File: rtl/prbs31_checker_if.sv
// PRBS31 checker bus: serial bit input with qualifier and counter clear,
// lock/error status and error/bit counters back from the checker.
interface prbs31_checker_if;
  logic        din;
  logic        din_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (
    output din, din_valid, clear_cnt,
    input  locked, err_pulse, err_count, bit_count
  );

  modport slave (
    input  din, din_valid, clear_cnt,
    output locked, err_pulse, err_count, bit_count
  );
endinterface

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31+x^28+1) receive checker: search/verify/lock with flywheel.
// Ports: clk, rst_n (async, active-high), bus (din/din_valid/clear_cnt in;
// locked/err_pulse/err_count/bit_count out).
module prbs31_checker #(
  parameter int LOCK_CNT = 64,
  parameter int WIN_LEN  = 256,
  parameter int LOSS_ERR = 8
) (
  input logic              clk,
  input logic              rst_n,
  prbs31_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [7:0]    WIN_LAST   = 8'(WIN_LEN - 1);
  localparam logic [3:0]    LOSS_LAST  = 4'(LOSS_ERR - 1);

  state_t          state_q, state_d;
  logic [30:0]     sr_q, sr_d;
  logic [4:0]      fill_q, fill_d;
  logic [MW-1:0]   match_q, match_d;
  logic [7:0]      win_q, win_d;
  logic [3:0]      werr_q, werr_d;
  logic            locked_q, locked_d;
  logic            pulse_q, pulse_d;
  logic [15:0]     errc_q, errc_d;
  logic [31:0]     bitc_q, bitc_d;

  logic pred;
  logic miss;

  assign pred = sr_q[30] ^ sr_q[27];
  assign miss = bus.din ^ pred;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    pulse_d = 1'b0;
    errc_d  = errc_q;
    bitc_d  = bitc_q;
    if (bus.din_valid) begin
      unique case (1'b1)
        (state_q == SEARCH): begin
          sr_d = {sr_q[29:0], bus.din};
          if (fill_q == 5'd30) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        (state_q == VERIFY): begin
          sr_d = {sr_q[29:0], bus.din};
          if (!miss && sr_q != '0) begin
            match_d = match_q + 1'b1;
            if (match_q == MATCH_LAST) begin
              state_d = LOCKED;
              win_d   = '0;
              werr_d  = '0;
            end
          end else begin
            // current bit becomes the first fill bit
            state_d = SEARCH;
            fill_d  = 5'd1;
          end
        end
        (state_q == LOCKED): begin
          // flywheel: received errors never enter sr
          sr_d = {sr_q[29:0], pred};
          if (bitc_q != '1) bitc_d = bitc_q + 32'd1;
          if (miss) begin
            pulse_d = 1'b1;
            if (errc_q != '1) errc_d = errc_q + 16'd1;
          end
          // loss of lock wins over window rollover
          if (miss && werr_q == LOSS_LAST) begin
            state_d = SEARCH;
            fill_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 8'd1;
            werr_d = werr_q + {3'b000, miss};
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (bus.clear_cnt) begin
      errc_d = '0;
      bitc_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      errc_q   <= '0;
      bitc_q   <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      errc_q   <= errc_d;
      bitc_q   <= bitc_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = errc_q;
  assign bus.bit_count = bitc_q;

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 Parameter LOCK_CNT, default 64: consecutive correct predictions required in VERIFY before LOCKED.
REQ-002 Parameter WIN_LEN, default 256: valid bits per loss-of-lock observation window.
REQ-003 Parameter LOSS_ERR, default 8: errors within one window that force loss of lock.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 din  input  1  received serial PRBS31 bit.
REQ-007 din_valid  input  1  qualifies din; state SHALL hold when low, except for clear_cnt.
REQ-008 clear_cnt  input  1  synchronous clear of err_count and bit_count.
REQ-009 locked  output  1  registered; high in LOCKED state only.
REQ-010 err_pulse  output  1  registered; one-cycle pulse per bit error detected in LOCKED.
REQ-011 err_count  output  16  saturating count of errors detected in LOCKED.
REQ-012 bit_count  output  32  saturating count of valid bits checked in LOCKED.

Function
REQ-013 Polynomial SHALL be x^31 + x^28 + 1; 31-bit shift register sr, sr[0] = most recent bit; predicted bit p = sr[30] XOR sr[27].
REQ-014 Every accepted bit SHALL shift sr left by one (sr[30:1] <= sr[29:0]) and load sr[0].
REQ-015 FSM states: SEARCH, VERIFY, LOCKED; encoding is free.
REQ-016 SEARCH: sr[0] <= din; 5-bit fill counter counts 31 valid bits, then -> VERIFY with match counter = 0.
REQ-017 VERIFY: sr[0] <= din; din == p with sr != 0 increments the match counter; on reaching LOCK_CNT -> LOCKED.
REQ-018 VERIFY: din != p, or sr == 0 (all-zero lockup), SHALL -> SEARCH with fill counter = 1 and the current din loaded as the first fill bit.
REQ-019 LOCKED: sr[0] <= p (flywheel, received errors never enter sr); din != p is one error.
REQ-020 LOCKED error: err_pulse = 1 in the cycle after the erroneous bit is sampled; err_count += 1, saturating at 0xFFFF.
REQ-021 LOCKED: bit_count += 1 per valid bit, saturating at 0xFFFFFFFF.
REQ-022 Window: 8-bit window counter plus 4-bit window error counter, both zeroed on LOCKED entry; both restart after WIN_LEN valid bits.
REQ-023 Window error counter reaching LOSS_ERR within one window SHALL -> SEARCH with fill counter = 0 on the next cycle; the error that reaches LOSS_ERR is still counted in err_count.
REQ-024 Window end coinciding with the LOSS_ERR-th error: loss of lock takes priority.
REQ-025 clear_cnt SHALL zero err_count and bit_count on the next edge regardless of din_valid and state, with priority over a simultaneous increment; FSM and sr are unaffected.
REQ-026 err_pulse SHALL be 0 in SEARCH and VERIFY and whenever din_valid was low.
REQ-027 locked SHALL fall on the same edge as the transition out of LOCKED.

Reset
REQ-028 rst_n high SHALL asynchronously force: state SEARCH; sr, fill, match, window and window-error counters = 0; locked = 0; err_pulse = 0; err_count = 0; bit_count = 0.
REQ-029 Reset asserted mid-lock SHALL discard all lock state; after release, reacquisition starts from SEARCH.

Verification
REQ-030 Feed the PRBS31 generator output (seed 1), din_valid = 1 -> locked rises after 95 valid bits (31 fill + 64 match); err_count stays 0; bit_count increments by 1 per cycle.
REQ-031 Invert a single din bit while locked -> exactly one err_pulse, err_count = 1, locked stays 1, no further errors.
REQ-032 Invert 8 bits within 256 bits while locked -> err_count = 8, locked falls one cycle after the 8th error, relock after 95 clean bits.
REQ-033 Constant din = 0 with din_valid = 1 for 500 cycles -> locked never asserts; FSM cycles SEARCH/VERIFY only.
REQ-034 Toggle din_valid 50 % while locked -> bit_count equals the number of valid bits; no errors; clear_cnt issued together with an error -> err_count = 0.
REQ-035 Assert rst_n while locked with err_count = 5 -> all outputs 0 immediately (asynchronously), before the next clock edge.
